// File: rtl/bcd_score_if.sv
// Score keeper bus: game-side controls in, score/display state out.
// master drives controls, slave is the score keeper.
interface bcd_score_if #(
   parameter int DIGITS = 5
);
   logic                  en;
   logic                  tick;
   logic [3:0]            inc;
   logic                  clr;
   logic [4*DIGITS-1:0]   score;
   logic [4*DIGITS-1:0]   hiscore;
   logic [7*DIGITS-1:0]   seg;
   logic                  new_high;
   logic                  overflow;

   modport master (
      output en, tick, inc, clr,
      input  score, hiscore, seg, new_high, overflow
   );

   modport slave (
      input  en, tick, inc, clr,
      output score, hiscore, seg, new_high, overflow
   );
endinterface

// File: rtl/bcd_score_keeper.sv
// N-digit packed-BCD score counter with high-score tracking,
// wrap/saturate overflow and 7-segment digit decode.
module bcd_score_keeper #(
   parameter int DIGITS   = 5,
   parameter int SATURATE = 1,
   parameter int BLANK_LZ = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   bcd_score_if.slave  bus
);
   localparam int W = 4 * DIGITS;

   logic [W-1:0]         score_q;
   logic [W-1:0]         hiscore_q;
   logic                 new_high_q;
   logic                 overflow_q;
   logic [3:0]           addend;
   logic [W-1:0]         sum;
   logic [W-1:0]         score_d;
   logic                 carry;
   logic [7*DIGITS-1:0]  seg_d;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h3F;
         4'd1:    seg7 = 7'h06;
         4'd2:    seg7 = 7'h5B;
         4'd3:    seg7 = 7'h4F;
         4'd4:    seg7 = 7'h66;
         4'd5:    seg7 = 7'h6D;
         4'd6:    seg7 = 7'h7D;
         4'd7:    seg7 = 7'h07;
         4'd8:    seg7 = 7'h7F;
         4'd9:    seg7 = 7'h6F;
         default: seg7 = 7'h00;
      endcase
   endfunction

   always_comb addend = (bus.inc > 4'd9) ? 4'd9 : bus.inc;

   // +6 mod 16 is the same as -10 on a nibble whose sum exceeded 9
   always_comb begin
      logic [4:0] s;
      s     = '0;
      sum   = '0;
      carry = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         s = {1'b0, score_q[4*k +: 4]} + {4'b0, carry};
         if (k == 0) s = s + {1'b0, addend};
         if (s > 5'd9) begin
            sum[4*k +: 4] = s[3:0] + 4'd6;
            carry         = 1'b1;
         end else begin
            sum[4*k +: 4] = s[3:0];
            carry         = 1'b0;
         end
      end
   end

   always_comb begin
      score_d = sum;
      if (carry && SATURATE != 0) score_d = {DIGITS{4'h9}};
   end

   // high-score compare sees the pre-clr score, so a final score is kept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q    <= '0;
         hiscore_q  <= '0;
         new_high_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (score_q > hiscore_q) begin
            hiscore_q  <= score_q;
            new_high_q <= 1'b1;
         end
         if (bus.clr) begin
            score_q    <= '0;
            new_high_q <= 1'b0;
            overflow_q <= 1'b0;
         end else if (bus.tick && bus.en) begin
            score_q <= score_d;
            if (carry) overflow_q <= 1'b1;
         end
      end
   end

   always_comb begin
      logic lead;
      lead  = 1'b1;
      seg_d = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         lead = lead & (score_q[4*k +: 4] == 4'd0);
         if (BLANK_LZ != 0 && k != 0 && lead)
            seg_d[7*k +: 7] = 7'h00;
         else
            seg_d[7*k +: 7] = seg7(score_q[4*k +: 4]);
      end
   end

   assign bus.score    = score_q;
   assign bus.hiscore  = hiscore_q;
   assign bus.seg      = seg_d;
   assign bus.new_high = new_high_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bcd_score_keeper.sv
// Bench for bcd_score_keeper: saturating/blanking and wrapping/unblanked
// instances driven in lockstep against a decimal-integer reference model.
module tb_bcd_score_keeper;
   localparam int D   = 5;
   localparam int MAX = 99999;
   localparam logic [6:0] SEG_TAB [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   logic clk;
   logic rst_n;

   bcd_score_if #(.DIGITS(D)) ifs ();
   bcd_score_if #(.DIGITS(D)) ifw ();

   bcd_score_keeper #(.DIGITS(D), .SATURATE(1), .BLANK_LZ(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(ifs)
   );
   bcd_score_keeper #(.DIGITS(D), .SATURATE(0), .BLANK_LZ(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .bus(ifw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: index 0 = saturating/blanking, 1 = wrapping/unblanked
   int m_score [2];
   int m_hi    [2];
   bit m_nh    [2];
   bit m_ov    [2];

   typedef struct {
      logic       en;
      logic       tick;
      logic [3:0] inc;
      logic       clr;
      int         score;
      int         hi;
      logic       nh;
      logic       ov;
   } vec_t;

   vec_t vt [12];

   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      int x;
      r = '0;
      x = v;
      for (int k = 0; k < D; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [34:0] seg_of(input int v, input bit blank);
      logic [34:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < D; k++) begin
         if (blank && k > 0 && v < p) r[7*k +: 7] = 7'h00;
         else r[7*k +: 7] = SEG_TAB[(v / p) % 10];
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_score[m] = 0;
         m_hi[m]    = 0;
         m_nh[m]    = 0;
         m_ov[m]    = 0;
      end
   endtask

   task automatic model_clock(input bit en, input bit tick,
                              input int inc, input bit clr);
      int a;
      int s;
      a = (inc > 9) ? 9 : inc;
      for (int m = 0; m < 2; m++) begin
         s = m_score[m];
         if (s > m_hi[m]) begin
            m_hi[m] = s;
            m_nh[m] = 1;
         end
         if (clr) begin
            m_score[m] = 0;
            m_nh[m]    = 0;
            m_ov[m]    = 0;
         end else if (en && tick) begin
            s = s + a;
            if (s > MAX) begin
               m_ov[m]    = 1;
               m_score[m] = (m == 0) ? MAX : s - (MAX + 1);
            end else begin
               m_score[m] = s;
            end
         end
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_s_score"}, 64'(ifs.score), 64'(to_bcd(m_score[0])));
      chk({tag, "_s_hi"}, 64'(ifs.hiscore), 64'(to_bcd(m_hi[0])));
      chk({tag, "_s_nh"}, 64'(ifs.new_high), 64'(m_nh[0]));
      chk({tag, "_s_ov"}, 64'(ifs.overflow), 64'(m_ov[0]));
      chk({tag, "_s_seg"}, 64'(ifs.seg), 64'(seg_of(m_score[0], 1'b1)));
      chk({tag, "_w_score"}, 64'(ifw.score), 64'(to_bcd(m_score[1])));
      chk({tag, "_w_hi"}, 64'(ifw.hiscore), 64'(to_bcd(m_hi[1])));
      chk({tag, "_w_nh"}, 64'(ifw.new_high), 64'(m_nh[1]));
      chk({tag, "_w_ov"}, 64'(ifw.overflow), 64'(m_ov[1]));
      chk({tag, "_w_seg"}, 64'(ifw.seg), 64'(seg_of(m_score[1], 1'b0)));
   endtask

   task automatic drive(input bit en, input bit tick,
                        input logic [3:0] inc, input bit clr);
      ifs.en = en; ifs.tick = tick; ifs.inc = inc; ifs.clr = clr;
      ifw.en = en; ifw.tick = tick; ifw.inc = inc; ifw.clr = clr;
   endtask

   task automatic step(input bit en, input bit tick, input logic [3:0] inc,
                       input bit clr, input bit do_chk, input string tag);
      @(negedge clk);
      drive(en, tick, inc, clr);
      @(posedge clk);
      model_clock(en, tick, int'(inc), clr);
      #1;
      if (do_chk) chk_all(tag);
   endtask

   task automatic load(input int target);
      int rem;
      int a;
      step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, "load");
      rem = target;
      while (rem > 0) begin
         a = (rem > 9) ? 9 : rem;
         step(1'b1, 1'b1, 4'(a), 1'b0, 1'b0, "load");
         rem = rem - a;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0);
      rst_n = 1'b0;
      model_reset();
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 4'd0, 1'b0);
      model_reset();

      vt[0]  = '{1'b1, 1'b1, 4'd3, 1'b0,  3,  0, 1'b0, 1'b0};
      vt[1]  = '{1'b1, 1'b1, 4'd9, 1'b0, 12,  3, 1'b1, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 4'd5, 1'b0, 12, 12, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 4'd5, 1'b0, 12, 12, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 1'b1, 4'hF, 1'b0, 21, 12, 1'b1, 1'b0};
      vt[5]  = '{1'b1, 1'b1, 4'd0, 1'b0, 21, 21, 1'b1, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 4'd5, 1'b1,  0, 21, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 4'd8, 1'b0,  8, 21, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 4'd9, 1'b0, 17, 21, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 4'd5, 1'b0, 22, 21, 1'b0, 1'b0};
      vt[10] = '{1'b1, 1'b0, 4'd0, 1'b0, 22, 22, 1'b1, 1'b0};
      vt[11] = '{1'b1, 1'b0, 4'd7, 1'b0, 22, 22, 1'b1, 1'b0};

      #12;
      chk("rst_s_score", 64'(ifs.score), 64'(0));
      chk("rst_s_hi", 64'(ifs.hiscore), 64'(0));
      chk("rst_s_flags", 64'({ifs.new_high, ifs.overflow}), 64'(0));
      chk("rst_s_seg", 64'(ifs.seg), 64'({28'h0, 7'h3F}));
      chk("rst_w_seg", 64'(ifw.seg), 64'({5{7'h3F}}));
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         step(vt[i].en, vt[i].tick, vt[i].inc, vt[i].clr, 1'b1, "tbl");
         chk($sformatf("tbl%0d_score", i), 64'(ifs.score),
             64'(to_bcd(vt[i].score)));
         chk($sformatf("tbl%0d_hi", i), 64'(ifs.hiscore),
             64'(to_bcd(vt[i].hi)));
         chk($sformatf("tbl%0d_flags", i),
             64'({ifs.new_high, ifs.overflow}), 64'({vt[i].nh, vt[i].ov}));
      end

      load(9);
      step(1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "t2");
      chk("t2_score", 64'(ifs.score), 64'(20'h00010));
      chk("t2_seg", 64'(ifs.seg), 64'({21'h0, 7'h06, 7'h3F}));

      load(9999);
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "t3a");
      step(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, "t3b");
      chk("t3_score", 64'(ifs.score), 64'(20'h10002));
      chk("t3_ov", 64'(ifs.overflow), 64'(0));
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "t3c");
      chk("t3_hi", 64'(ifs.hiscore), 64'(20'h10002));

      load(99998);
      step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, "t4a");
      chk("t4_sat", 64'(ifs.score), 64'(20'h99999));
      chk("t4_wrap", 64'(ifw.score), 64'(20'h00003));
      chk("t4_ov", 64'({ifs.overflow, ifw.overflow}), 64'(2'b11));
      step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, "t4b");
      chk("t4_sat_hold", 64'(ifs.score), 64'(20'h99999));

      do_reset();
      load(120);
      step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, "t5");
      chk("t5_score", 64'(ifs.score), 64'(0));
      chk("t5_hi", 64'(ifs.hiscore), 64'(20'h00120));
      chk("t5_nh", 64'(ifs.new_high), 64'(0));

      step(1'b1, 1'b1, 4'hC, 1'b0, 1'b1, "t6a");
      chk("t6_clamp", 64'(ifs.score), 64'(20'h00009));
      step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, "t6b");
      chk("t6_en0", 64'(ifs.score), 64'(20'h00009));

      @(negedge clk);
      drive(1'b1, 1'b1, 4'd5, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("t6rst");
      chk("t6_rst_all", 64'({ifs.score, ifs.hiscore, ifs.new_high}), 64'(0));
      @(negedge clk);
      chk_all("t6rst2");
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 1'b0);

      load(99900);
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
              4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0,
              1'b1, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
